// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M execute-stage multiply/divide sequencer.
`timescale 1ns/1ps
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    // Most negative XLEN_DEF-bit value; the signed-overflow dividend.
    localparam logic [XLEN_DEF-1:0] XLEN_MIN_NEG = {1'b1, {(XLEN_DEF-1){1'b0}}};

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // mult_func encodings (shared with main_decoder)
    localparam logic [1:0] MF_MUL    = 2'b00;
    localparam logic [1:0] MF_MULH   = 2'b01;
    localparam logic [1:0] MF_MULHU  = 2'b10;
    localparam logic [1:0] MF_MULHSU = 2'b11;

    // div_func encodings (shared with main_decoder)
    localparam logic [1:0] DF_DIV  = 2'b00;
    localparam logic [1:0] DF_DIVU = 2'b01;
    localparam logic [1:0] DF_REM  = 2'b10;
    localparam logic [1:0] DF_REMU = 2'b11;

    // Per-operation context captured at launch.
    // For multiply neg_lo == neg_hi (whole product negated);
    // for divide neg_lo is the quotient sign, neg_hi the remainder sign.
    typedef struct packed {
        logic       is_div;
        logic [1:0] func;
        logic       neg_lo;
        logic       neg_hi;
    } op_ctx_t;

endpackage

// File: rtl/muldiv_iter_unit.sv
// Radix-2 iterative datapath: unsigned shift-add multiply and restoring
// divide share one 2*XLEN accumulator. Sign correction is applied in the
// FIX cycle; the outputs show the corrected value during that cycle so the
// sequencer can capture the result on the same edge.
`timescale 1ns/1ps
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              fix,
    input  logic              is_div,
    input  logic              neg_lo,
    input  logic              neg_hi,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    // acc: multiply {partial product, multiplier}; divide {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;        // multiplicand or divisor
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] acc_fixed;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   lo_val;
    logic [XLEN-1:0]   hi_val;

    // One iteration: add-then-shift-right for multiply, shift-subtract for divide
    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            // diff[XLEN] set means the trial subtraction went negative: restore
            if (diff[XLEN])
                acc_step = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {add_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction: whole product for multiply, halves separately for divide
    always_comb begin
        lo_val = neg_lo ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        hi_val = neg_hi ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        if (is_div)
            acc_fixed = {hi_val, lo_val};
        else
            acc_fixed = neg_lo ? (~acc + 1'b1) : acc;
    end

    // Accumulator/operand registers: load has priority over step over fix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{XLEN{1'b0}}, op_a};
            opnd <= op_b;
        end else if (step) begin
            acc  <= acc_step;
        end else if (fix) begin
            acc  <= acc_fixed;
        end
    end

    assign product   = fix ? acc_fixed : acc;
    assign quotient  = product[XLEN-1:0];
    assign remainder = product[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage RV32M controller: launches multiply/divide ops, sequences the
// iterative datapath, short-circuits divide-by-zero and signed overflow,
// and stalls the pipeline until the registered result is ready.
`timescale 1ns/1ps
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_mult_E,
    input  logic            start_div_E,
    input  logic [1:0]      mult_func_E,
    input  logic [1:0]      div_func_E,
    input  logic [XLEN-1:0] srcA_E,
    input  logic [XLEN-1:0] srcB_E,
    input  logic            flush_E,
    output logic            muldiv_stall,
    output logic            muldiv_valid,
    output logic [XLEN-1:0] muldiv_result
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    op_ctx_t           ctx, ctx_in;

    logic              launch;
    logic              a_sgn_en, b_sgn_en;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special, is_rem_in;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   fixed_res;

    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder;

    // Launch is also held off during reset so stall reads 0 while rst_n is low.
    assign launch = (state == ST_IDLE) & (start_mult_E | start_div_E) & ~flush_E & rst_n;

    // Decode signedness, magnitudes, special cases and captured context
    always_comb begin
        if (start_mult_E) begin
            a_sgn_en = (mult_func_E == MF_MULH) || (mult_func_E == MF_MULHSU);
            b_sgn_en = (mult_func_E == MF_MULH);
        end else begin
            a_sgn_en = (div_func_E == DF_DIV) || (div_func_E == DF_REM);
            b_sgn_en = a_sgn_en;
        end
        sa    = a_sgn_en & srcA_E[XLEN-1];
        sb    = b_sgn_en & srcB_E[XLEN-1];
        a_mag = sa ? (~srcA_E + 1'b1) : srcA_E;
        b_mag = sb ? (~srcB_E + 1'b1) : srcB_E;

        // multiply wins if both strobes are high
        ctx_in.is_div = ~start_mult_E;
        ctx_in.func   = start_mult_E ? mult_func_E : div_func_E;
        ctx_in.neg_lo = sa ^ sb;
        ctx_in.neg_hi = start_mult_E ? (sa ^ sb) : sa;

        is_rem_in = (div_func_E == DF_REM) || (div_func_E == DF_REMU);
        div_zero  = ~start_mult_E & (srcB_E == '0);
        div_ovf   = ~start_mult_E & a_sgn_en & (srcA_E == MIN_NEG) & (&srcB_E);
        special   = div_zero | div_ovf;

        if (div_zero)
            special_res = is_rem_in ? srcA_E : '1;
        else
            special_res = is_rem_in ? '0 : MIN_NEG;
    end

    // Pick the architectural result out of the sign-corrected datapath
    always_comb begin
        if (ctx.is_div)
            fixed_res = ((ctx.func == DF_REM) || (ctx.func == DF_REMU)) ? remainder : quotient;
        else
            fixed_res = (ctx.func == MF_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush aborts CALC/FIX, DONE always retires to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (flush_E) state_nxt = ST_IDLE;
                     else if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = flush_E ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, iteration counter, op context and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ctx           <= '0;
            muldiv_result <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                cnt <= '0;
                ctx <= ctx_in;
                if (special) muldiv_result <= special_res;
            end else if (state == ST_CALC) begin
                cnt <= (flush_E || cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else if (state == ST_FIX && !flush_E) begin
                muldiv_result <= fixed_res;
            end
        end
    end

    assign muldiv_stall = launch | (state == ST_CALC) | (state == ST_FIX);
    assign muldiv_valid = (state == ST_DONE) & ~flush_E;

    muldiv_iter_unit #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (launch),
        .step      (state == ST_CALC),
        .fix       (state == ST_FIX),
        .is_div    (ctx.is_div),
        .neg_lo    (ctx.neg_lo),
        .neg_hi    (ctx.neg_hi),
        .op_a      (a_mag),
        .op_b      (b_mag),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Execute-stage controller for the RV32M extension in the 5-stage pipeline.
- Accepts the decoded start_mult/start_div strobes and function codes once they reach EX, and sequences a shared radix-2 iterative multiply/divide datapath.
- Handles RISC-V special cases (divide by zero, signed overflow) and drives the stall that holds the pipeline until the result is ready.
- Its result is selected in EX when ALUResultSrc is 1.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- start_mult_E  in  1  multiply instruction present in EX
- start_div_E  in  1  divide/remainder instruction present in EX
- mult_func_E  in  2  00 mul, 01 mulh, 10 mulhu, 11 mulhsu
- div_func_E  in  2  00 div, 01 divu, 10 rem, 11 remu
- srcA_E  in  XLEN  forwarded rs1 value
- srcB_E  in  XLEN  forwarded rs2 value
- flush_E  in  1  EX flush from hazard unit
- muldiv_stall  out  1  stall request to hazard unit (combinational)
- muldiv_valid  out  1  result valid; one-cycle pulse
- muldiv_result  out  XLEN  result to the EX result mux

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (asynchronous, active-low):
  - state=IDLE, counter=0, all internal registers=0.
  - muldiv_valid=0, muldiv_result=0, muldiv_stall=0.
- Launch:
  - In IDLE with (start_mult_E | start_div_E) & ~flush_E in cycle T, operands, function and sign flags are latched at the end of T.
  - If both starts are high, multiply wins; the decoder never issues this.
- muldiv_stall = (IDLE & start & ~flush_E) | CALC | FIX. It is 0 in DONE, so the instruction advances with its result.
- Signed handling:
  - Magnitudes are taken for signed operands: mulh uses A and B; mulhsu uses A only; div/rem use A and B.
  - Sign flags are recorded at launch.
- Multiply (CALC):
  - Unsigned shift-add over XLEN cycles on a 2*XLEN product register.
  - FIX negates the 64-bit product if the operand signs differ (mulhsu: sign of A only).
  - mul returns the low XLEN bits; the others return the high XLEN bits.
- Divide (CALC):
  - Unsigned restoring division over XLEN cycles, producing quotient and remainder.
  - FIX: quotient sign = sA^sB and remainder sign = sA (signed ops only).
- Normal latency:
  - IDLE -> CALC (XLEN cycles) -> FIX (1) -> DONE (1) -> IDLE.
  - muldiv_valid is high in cycle T+XLEN+2; stall is high in cycles T..T+XLEN+1.
- Special cases skip CALC/FIX; IDLE -> DONE gives valid at T+1 and stall in cycle T only:
  - Divisor 0: div/divu = all ones; rem/remu = dividend.
  - Signed overflow, -2^(XLEN-1) / -1: div = -2^(XLEN-1); rem = 0.
- muldiv_result is registered and holds its value until the next DONE. It is meaningful only when muldiv_valid=1.
- DONE always returns to IDLE. A start seen during DONE is the same instruction still in EX and is ignored.
- Back-to-back instructions relaunch from IDLE in the following cycle.
- flush_E:
  - In CALC or FIX: abort to IDLE at the next edge; no muldiv_valid; stall drops the next cycle.
  - In IDLE: suppresses launch.
  - In DONE: suppresses valid.
- Counter counts 0..XLEN-1 and is cleared on launch and on abort.

Decomposition:
- Package muldiv_pkg holds:
  - state encodings;
  - mult/div func encodings shared with main_decoder;
  - constant XLEN_MIN_NEG.
- One sub-module, muldiv_iter_unit, holds the iterative shift-add/restoring datapath: load, step and sign-fix controls from the sequencer; outputs the product register and the quotient/remainder registers.
- The FSM, special-case detection and stall logic stay in muldiv_sequencer.

Test Plan:
- mul, A=7, B=0xFFFFFFFD (-3) at cycle T -> muldiv_valid at T+34 with result 0xFFFFFFEB; stall high T..T+33.
- mulh, A=B=0x80000000 -> 0x40000000; mulhu, A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- div and rem, A=0xFFFFFFF9 (-7), B=2 -> div 0xFFFFFFFD, rem 0xFFFFFFFF; divu, A=7, B=2 -> 3.
- div/rem, A=7, B=0 -> div 0xFFFFFFFF, rem 7, valid at T+1; div, A=0x80000000, B=0xFFFFFFFF -> 0x80000000, rem 0, valid at T+1.
- Flush: start divu, assert flush_E at T+10 -> no valid pulse, stall low from T+11, IDLE; a new mul at T+12 completes normally.
- Reset: rst_n low at T+5 of a mul -> outputs 0 immediately; after release with start held, a fresh launch runs with full latency.
